// File: rtl/e1_rx_framer_pkg.sv
//==============================================================================
// Module  : e1_rx_framer_pkg
// Brief   : Shared E1 basic-frame constants and the framer state encoding.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package e1_rx_framer_pkg;

   localparam logic [6:0] c_e1_fas        = 7'b0011011;
   localparam int         c_e1_frame_bits = 256;
   localparam logic [7:0] c_e1_fas_pos    = 8'd7;   // last FAS bit in TS0
   localparam logic [7:0] c_e1_nfas_pos   = 8'd1;   // NFAS "bit 2" in TS0

   typedef enum logic [1:0] {
      ST_SEARCH     = 2'd0,
      ST_CHECK_NFAS = 2'd1,
      ST_CHECK_FAS2 = 2'd2,
      ST_ALIGNED    = 2'd3
   } e1_state_t;

   function automatic logic is_fas(input logic [6:0] win);
      return (win == c_e1_fas);
   endfunction

endpackage

`default_nettype wire

// File: rtl/e1_rx_framer_if.sv
//==============================================================================
// Module  : e1_rx_framer_if
// Brief   : Bit-stream input and annotated bit-stream output of the E1 framer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface e1_rx_framer_if;
   logic       in_data;
   logic       in_valid;
   logic       out_data;
   logic       out_valid;
   logic [4:0] out_ts;
   logic [2:0] out_bit;
   logic       out_odd;
   logic       out_aligned;
   logic       out_fas_err;

   modport master (
      output in_data, in_valid,
      input  out_data, out_valid, out_ts, out_bit, out_odd, out_aligned, out_fas_err
   );

   modport slave (
      input  in_data, in_valid,
      output out_data, out_valid, out_ts, out_bit, out_odd, out_aligned, out_fas_err
   );
endinterface

`default_nettype wire

// File: rtl/e1_rx_framer.sv
//==============================================================================
// Module  : e1_rx_framer
// Brief   : E1 receive basic-frame aligner (FAS/NFAS search, 256-bit lock).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module e1_rx_framer
   import e1_rx_framer_pkg::*;
#(
   parameter int LOSS_THRESH = 3,
   parameter bit NFAS_CHECK  = 1'b1
) (
   input  wire logic     clk,
   input  wire logic     rst,
   e1_rx_framer_if.slave bus
);

   localparam logic [2:0] c_loss_thresh = 3'(LOSS_THRESH);

   e1_state_t  r_state;
   e1_state_t  w_state_nxt;
   logic [7:0] r_pos;
   logic       r_odd;
   logic [5:0] r_sr;
   logic [2:0] r_err_cnt;
   logic [2:0] w_err_nxt;
   logic [2:0] w_err_inc;
   logic [6:0] w_win;
   logic       w_fas_hit;
   logic       w_nfas_ok;
   logic       w_fas_slot;
   logic       w_fas_err;
   logic [7:0] w_cur_pos;
   logic       w_cur_odd;

   logic       r_out_data;
   logic       r_out_valid;
   logic [4:0] r_out_ts;
   logic [2:0] r_out_bit;
   logic       r_out_odd;
   logic       r_out_aligned;
   logic       r_out_fas_err;

   assign w_win      = {r_sr, bus.in_data};
   assign w_fas_hit  = is_fas(w_win);
   assign w_fas_slot = (r_pos == c_e1_fas_pos) && !r_odd;
   assign w_err_inc  = r_err_cnt + 3'd1;

   generate
      if (NFAS_CHECK) begin : g_nfas_chk
         assign w_nfas_ok = bus.in_data;
      end else begin : g_nfas_skip
         assign w_nfas_ok = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_SEARCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err_cnt;
      w_fas_err   = 1'b0;
      w_cur_pos   = r_pos;
      w_cur_odd   = r_odd;
      if (bus.in_valid) begin
         case (r_state)
            ST_SEARCH: begin
               // A hit pins this bit to TS0 bit 7 of an even frame.
               if (w_fas_hit) begin
                  w_cur_pos   = c_e1_fas_pos;
                  w_cur_odd   = 1'b0;
                  w_state_nxt = ST_CHECK_NFAS;
               end
            end
            ST_CHECK_NFAS: begin
               if ((r_pos == c_e1_nfas_pos) && r_odd) begin
                  w_state_nxt = w_nfas_ok ? ST_CHECK_FAS2 : ST_SEARCH;
               end
            end
            ST_CHECK_FAS2: begin
               if (w_fas_slot) begin
                  w_state_nxt = w_fas_hit ? ST_ALIGNED : ST_SEARCH;
                  w_err_nxt   = 3'd0;
               end
            end
            ST_ALIGNED: begin
               if (w_fas_slot) begin
                  if (w_fas_hit) begin
                     w_err_nxt = 3'd0;
                  end else begin
                     w_fas_err = 1'b1;
                     w_err_nxt = w_err_inc;
                     if (w_err_inc >= c_loss_thresh) begin
                        w_state_nxt = ST_SEARCH;
                     end
                  end
               end
            end
            default: w_state_nxt = ST_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pos         <= 8'd0;
         r_odd         <= 1'b0;
         r_sr          <= 6'd0;
         r_err_cnt     <= 3'd0;
         r_out_data    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_ts      <= 5'd0;
         r_out_bit     <= 3'd0;
         r_out_odd     <= 1'b0;
         r_out_aligned <= 1'b0;
         r_out_fas_err <= 1'b0;
      end else begin
         r_out_valid   <= bus.in_valid;
         r_out_fas_err <= w_fas_err;
         r_out_aligned <= (w_state_nxt == ST_ALIGNED);
         if (bus.in_valid) begin
            r_pos      <= w_cur_pos + 8'd1;
            r_odd      <= w_cur_odd ^ (w_cur_pos == 8'hFF);
            r_sr       <= {r_sr[4:0], bus.in_data};
            r_err_cnt  <= w_err_nxt;
            r_out_data <= bus.in_data;
            r_out_ts   <= w_cur_pos[7:3];
            r_out_bit  <= w_cur_pos[2:0];
            r_out_odd  <= w_cur_odd;
         end
      end
   end

   assign bus.out_data    = r_out_data;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_ts      = r_out_ts;
   assign bus.out_bit     = r_out_bit;
   assign bus.out_odd     = r_out_odd;
   assign bus.out_aligned = r_out_aligned;
   assign bus.out_fas_err = r_out_fas_err;

endmodule

`default_nettype wire

// File: tb/tb_e1_rx_framer.sv
//==============================================================================
// Module  : tb_e1_rx_framer
// Brief   : Directed self-checking bench for e1_rx_framer (two NFAS_CHECK builds).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_e1_rx_framer;
   import e1_rx_framer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   e1_rx_framer_if bus0 ();
   e1_rx_framer_if bus1 ();

   e1_rx_framer #(.LOSS_THRESH(3), .NFAS_CHECK(1'b1)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   e1_rx_framer #(.LOSS_THRESH(3), .NFAS_CHECK(1'b0)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Stream generator controls
   int fake_frame      = -1;
   int nfas_zero_frame = -1;
   bit bad_fas [0:31];

   // Event trackers (absolute bit index = frame*256 + pos)
   int   rise0, fall0, rise1, n_err_pulse0, n_in_valid, n_out_valid, idle_bad;
   logic prev_al0, prev_al1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic gen_bit(input int f, input int p);
      logic [7:0] byte_v;
      int ts;
      int b;
      ts = p / 8;
      b  = p % 8;
      if (ts == 0) begin
         if (f % 2 == 0) begin
            byte_v = 8'b1001_1011;
            if (f < 32 && bad_fas[f]) byte_v[0] = ~byte_v[0];
         end else begin
            byte_v = 8'b1101_1111;
            if (f == nfas_zero_frame) byte_v[6] = 1'b0;
         end
      end else if (f == fake_frame && ts == 5) begin
         byte_v = 8'b1001_1011;
      end else begin
         // Neither payload byte contains "00", so no FAS can form in payload.
         byte_v = (ts % 2 == 1) ? 8'hB5 : 8'hDB;
      end
      return byte_v[7-b];
   endfunction

   task automatic clear_trk();
      rise0 = -1; fall0 = -1; rise1 = -1;
      n_err_pulse0 = 0; n_in_valid = 0; n_out_valid = 0; idle_bad = 0;
      prev_al0 = 1'b0; prev_al1 = 1'b0;
   endtask

   task automatic drive(input logic d, input logic v, input int f, input int p);
      logic [9:0] got;
      logic [9:0] want;
      bus0.in_data = d; bus0.in_valid = v;
      bus1.in_data = d; bus1.in_valid = v;
      @(posedge clk);
      #1;
      if (v) n_in_valid++;
      if (bus0.out_valid) n_out_valid++;
      if (!v && (bus0.out_valid || bus0.out_fas_err)) idle_bad++;
      if (bus0.out_fas_err) n_err_pulse0++;
      if (bus0.out_aligned && !prev_al0) rise0 = f * 256 + p;
      if (!bus0.out_aligned && prev_al0) fall0 = f * 256 + p;
      if (bus1.out_aligned && !prev_al1) rise1 = f * 256 + p;
      prev_al0 = bus0.out_aligned;
      prev_al1 = bus1.out_aligned;
      if (v && bus0.out_aligned) begin
         got  = {bus0.out_data, bus0.out_ts, bus0.out_bit, bus0.out_odd};
         want = {d, 5'(p / 8), 3'(p % 8), 1'(f % 2)};
         check_val("track", 32'(got), 32'(want));
      end
   endtask

   task automatic run(input int a_lo, input int a_hi, input int duty);
      int k;
      for (int a = a_lo; a <= a_hi; a++) begin
         if (duty < 100) begin
            k = 0;
            while (k < 8 && $urandom_range(99) >= duty) begin
               drive(1'b0, 1'b0, a / 256, a % 256);
               k++;
            end
         end
         drive(gen_bit(a / 256, a % 256), 1'b1, a / 256, a % 256);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus0.in_data = 1'b0; bus0.in_valid = 1'b0;
      bus1.in_data = 1'b0; bus1.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_out0", 32'({bus0.out_data, bus0.out_valid, bus0.out_ts, bus0.out_bit,
                                 bus0.out_odd, bus0.out_aligned, bus0.out_fas_err}), 32'd0);
      check_val("rst_out1", 32'({bus1.out_data, bus1.out_valid, bus1.out_ts, bus1.out_bit,
                                 bus1.out_odd, bus1.out_aligned, bus1.out_fas_err}), 32'd0);
      rst = 1'b0;
      clear_trk();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) bad_fas[i] = 1'b0;
      bus0.in_data = 1'b0; bus0.in_valid = 1'b0;
      bus1.in_data = 1'b0; bus1.in_valid = 1'b0;
      clear_trk();
      repeat (2) @(posedge clk);
      do_reset();

      // Clean stream from frame 0 bit 0
      run(0, 4 * 256 - 1, 100);
      check_val("clean_rise0", 32'(rise0), 32'd519);
      check_val("clean_rise1", 32'(rise1), 32'd519);
      check_val("clean_err", 32'(n_err_pulse0), 32'd0);

      // Two errored FAS words then a clean one: lock is kept
      bad_fas[4] = 1'b1; bad_fas[6] = 1'b1;
      run(4 * 256, 10 * 256 - 1, 100);
      check_val("err2_pulses", 32'(n_err_pulse0), 32'd2);
      check_val("err2_nofall", 32'(fall0), 32'hFFFF_FFFF);

      // Three consecutive errors drop lock; reacquire two FAS frames later
      bad_fas[10] = 1'b1; bad_fas[12] = 1'b1; bad_fas[14] = 1'b1;
      run(10 * 256, 18 * 256 + 8, 100);
      check_val("err3_pulses", 32'(n_err_pulse0), 32'd5);
      check_val("err3_fall", 32'(fall0), 32'(14 * 256 + 7));
      check_val("err3_rise", 32'(rise0), 32'(18 * 256 + 7));

      // Reset while aligned, then reacquire 512 bits after the next FAS
      run(18 * 256 + 9, 20 * 256 + 99, 100);
      do_reset();
      run(20 * 256 + 100, 24 * 256 + 8, 100);
      check_val("rst_rise0", 32'(rise0), 32'(24 * 256 + 7));
      for (int i = 0; i < 32; i++) bad_fas[i] = 1'b0;

      // Gapped in_valid, ~50% duty
      do_reset();
      run(0, 4 * 256 - 1, 50);
      check_val("gap_rise0", 32'(rise0), 32'd519);
      check_val("gap_vcount", 32'(n_out_valid), 32'(n_in_valid));
      check_val("gap_idle", 32'(idle_bad), 32'd0);

      // False FAS in TS5 ahead of the true one is rejected at the NFAS check
      do_reset();
      fake_frame = 0;
      run(8, 4 * 256 + 10, 100);
      check_val("fake_rise0", 32'(rise0), 32'(4 * 256 + 7));
      fake_frame = -1;

      // NFAS bit forced to 0: only the NFAS_CHECK=0 build locks on frame 2
      do_reset();
      nfas_zero_frame = 1;
      run(0, 4 * 256 + 10, 100);
      check_val("nfas_rise1", 32'(rise1), 32'd519);
      check_val("nfas_rise0", 32'(rise0), 32'(4 * 256 + 7));
      nfas_zero_frame = -1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
